alarm_clock_multi: RTL and testbench

- Next-generation timekeeping core for the lab alarm clock.
- Adds to the existing sec/min/hr datapath:
  - a day-of-week counter;
  - NALM independently settable alarms;
  - a per-alarm ring/snooze state machine with auto-timeout.
- Outputs are binary and 7 bits wide so they drive the existing lcd_int display drivers directly.
- Single clock domain; the 1 Hz pulse arrives as a one-cycle enable, not as a clock.

---
 rtl/alarm_clock_multi.sv | 200 ++++++++++++++++++++
 tb/tb_alarm_clock_multi.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock_multi.sv
// Timekeeping core: sec/min/hr/day counters plus NALM alarms, each with its own ring/snooze/timeout FSM.
// Optional build macro ALARM_DAYMASK_EN adds the amask input that arms each alarm per weekday.
module alarm_clock_multi #(
    parameter int NS         = 60,
    parameter int NH         = 24,
    parameter int ND         = 7,
    parameter int NALM       = 2,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 30,
    localparam int SELW      = (NALM > 1) ? $clog2(NALM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse,
    input  logic              timeset,
    input  logic              alarmset,
    input  logic [SELW-1:0]   alarm_sel,
    input  logic              minadv,
    input  logic              hrsadv,
    input  logic              dayadv,
    input  logic [NALM-1:0]   alarm_on,
    input  logic              snooze,
    input  logic              stop,
`ifdef ALARM_DAYMASK_EN
    input  logic [NALM*ND-1:0] amask,
`endif
    output logic [6:0]        tsec,
    output logic [6:0]        tmin,
    output logic [6:0]        thrs,
    output logic [2:0]        tday,
    output logic [6:0]        disp_min,
    output logic [6:0]        disp_hrs,
    output logic              buzz,
    output logic [NALM-1:0]   ring_vec
);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} alm_state_t;

    localparam logic [7:0] RING_LD = 8'(RING_SEC);
    localparam logic [6:0] SNZ_LD  = 7'(SNOOZE_MIN);

    function automatic logic [6:0] inc_mod(input logic [6:0] v, input int m);
        return (int'(v) >= m - 1) ? 7'd0 : v + 7'd1;
    endfunction

    function automatic logic [2:0] inc_day(input logic [2:0] v);
        return (int'(v) >= ND - 1) ? 3'd0 : v + 3'd1;
    endfunction

    logic tset_m, aset_m, run_m;
    logic sec_wrap, min_wrap, hr_wrap;
    logic mev;
    logic sel_ok;
    logic [SELW-1:0] sel_eff;
    logic [6:0] amin_a [NALM];
    logic [6:0] ahrs_a [NALM];

    // timeset outranks alarmset; neither pressed means RUN
    assign tset_m = timeset;
    assign aset_m = !timeset && alarmset;
    assign run_m  = !timeset && !alarmset;

    assign sec_wrap = (int'(tsec) >= NS - 1);
    assign min_wrap = (int'(tmin) >= NS - 1);
    assign hr_wrap  = (int'(thrs) >= NH - 1);

    assign sel_ok  = (int'(alarm_sel) < NALM);
    assign sel_eff = sel_ok ? alarm_sel : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tsec <= '0;
            tmin <= '0;
            thrs <= '0;
            tday <= '0;
            mev  <= 1'b0;
        end else begin
            mev <= 1'b0;
            if (tset_m) begin
                tsec <= '0;
                if (pulse) begin
                    if (minadv) tmin <= inc_mod(tmin, NS);
                    if (hrsadv) thrs <= inc_mod(thrs, NH);
                    if (dayadv) tday <= inc_day(tday);
                end
            end else if (pulse) begin
                tsec <= inc_mod(tsec, NS);
                if (sec_wrap) begin
                    // minute strobe only for RUN-mode rollovers; the FSMs see it one clk later
                    mev  <= run_m;
                    tmin <= inc_mod(tmin, NS);
                    if (min_wrap) begin
                        thrs <= inc_mod(thrs, NH);
                        if (hr_wrap) tday <= inc_day(tday);
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NALM; g++) begin : g_alm
        logic [6:0] amin_q, ahrs_q;
        logic [7:0] rct_q, rct_d;
        logic [6:0] sct_q, sct_d;
        alm_state_t st_q, st_d;
        logic ring_q;
        logic sel_hit, day_ok, hit;

        assign sel_hit = aset_m && pulse && sel_ok && (int'(alarm_sel) == g);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                amin_q <= '0;
                ahrs_q <= '0;
            end else if (sel_hit) begin
                if (minadv) amin_q <= inc_mod(amin_q, NS);
                if (hrsadv) ahrs_q <= inc_mod(ahrs_q, NH);
            end
        end

        assign amin_a[g] = amin_q;
        assign ahrs_a[g] = ahrs_q;

`ifdef ALARM_DAYMASK_EN
        logic [ND-1:0] dmask;
        assign dmask  = amask[g*ND +: ND];
        assign day_ok = dmask[tday];
`else
        assign day_ok = 1'b1;
`endif

        assign hit = mev && (tmin == amin_q) && (thrs == ahrs_q) && day_ok;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                st_q   <= IDLE;
                rct_q  <= '0;
                sct_q  <= '0;
                ring_q <= 1'b0;
            end else begin
                st_q   <= st_d;
                rct_q  <= rct_d;
                sct_q  <= sct_d;
                ring_q <= (st_d == RINGING);
            end
        end

        always_comb begin
            st_d  = st_q;
            rct_d = rct_q;
            sct_d = sct_q;
            case (st_q)
                IDLE: begin
                    if (hit) begin
                        st_d  = RINGING;
                        rct_d = RING_LD;
                    end
                end
                RINGING: begin
                    if (stop) begin
                        st_d = IDLE;
                    end else if (snooze) begin
                        st_d  = SNOOZED;
                        sct_d = SNZ_LD;
                    end else if (pulse) begin
                        if (rct_q <= 8'd1) begin
                            st_d  = IDLE;
                            rct_d = '0;
                        end else begin
                            rct_d = rct_q - 8'd1;
                        end
                    end
                end
                SNOOZED: begin
                    // a fresh time match is deliberately ignored while snoozed
                    if (stop) begin
                        st_d = IDLE;
                    end else if (mev) begin
                        if (sct_q <= 7'd1) begin
                            st_d  = RINGING;
                            sct_d = '0;
                            rct_d = RING_LD;
                        end else begin
                            sct_d = sct_q - 7'd1;
                        end
                    end
                end
                default: st_d = IDLE;
            endcase
            if (!alarm_on[g] || tset_m) st_d = IDLE;
        end

        assign ring_vec[g] = ring_q;
    end

    assign disp_min = aset_m ? amin_a[sel_eff] : tmin;
    assign disp_hrs = aset_m ? ahrs_a[sel_eff] : thrs;
    assign buzz     = |ring_vec;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Directed bench for alarm_clock_multi: a seconds-of-week model checked every clk plus literal checkpoints.
`timescale 1ns/1ps
module tb_alarm_clock_multi;
    localparam int NS = 60, NH = 24, ND = 7, NALM = 2, SNOOZE_MIN = 5, RING_SEC = 30;
    localparam int SELW = 1;
    localparam int WEEK = NS * NS * NH * ND;
    localparam int S_IDLE = 0, S_RING = 1, S_SNZ = 2;

    logic clk = 1'b0, rst = 1'b0, pulse = 1'b0, timeset = 1'b0, alarmset = 1'b0;
    logic minadv = 1'b0, hrsadv = 1'b0, dayadv = 1'b0, snooze = 1'b0, stop = 1'b0;
    logic [SELW-1:0] alarm_sel = '0;
    logic [NALM-1:0] alarm_on = '0;
`ifdef ALARM_DAYMASK_EN
    logic [NALM*ND-1:0] amask = '0;
`endif
    logic [6:0] tsec, tmin, thrs, disp_min, disp_hrs;
    logic [2:0] tday;
    logic buzz;
    logic [NALM-1:0] ring_vec;

    int n_err = 0, n_chk = 0;

    int m_tw;
    bit m_mev;
    int a_min [NALM];
    int a_hr [NALM];
    int st [NALM];
    int rleft [NALM];
    int sleft [NALM];

    alarm_clock_multi #(.NS(NS), .NH(NH), .ND(ND), .NALM(NALM),
                        .SNOOZE_MIN(SNOOZE_MIN), .RING_SEC(RING_SEC)) dut (
        .clk(clk), .rst(rst), .pulse(pulse), .timeset(timeset), .alarmset(alarmset),
        .alarm_sel(alarm_sel), .minadv(minadv), .hrsadv(hrsadv), .dayadv(dayadv),
        .alarm_on(alarm_on), .snooze(snooze), .stop(stop),
`ifdef ALARM_DAYMASK_EN
        .amask(amask),
`endif
        .tsec(tsec), .tmin(tmin), .thrs(thrs), .tday(tday),
        .disp_min(disp_min), .disp_hrs(disp_hrs), .buzz(buzz), .ring_vec(ring_vec));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int f_sec(); return m_tw % NS; endfunction
    function automatic int f_min(); return (m_tw / NS) % NS; endfunction
    function automatic int f_hr();  return (m_tw / (NS * NS)) % NH; endfunction
    function automatic int f_day(); return m_tw / (NS * NS * NH); endfunction

    function automatic bit day_ok(input int i);
`ifdef ALARM_DAYMASK_EN
        logic [NALM*ND-1:0] sh;
        sh = amask >> (i * ND + f_day());
        return sh[0];
`else
        return (i >= 0);
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tw = 0;
        m_mev = 1'b0;
        for (int i = 0; i < NALM; i++) begin
            a_min[i] = 0; a_hr[i] = 0; st[i] = S_IDLE; rleft[i] = 0; sleft[i] = 0;
        end
    endtask

    // Advances the model by one clk using the inputs that were present at the edge.
    task automatic model_step();
        bit tm, am, rm, nmev;
        int s, mi, h, d, sel;
        if (!rst) begin
            model_reset();
            return;
        end
        tm = timeset;
        am = !timeset && alarmset;
        rm = !timeset && !alarmset;
        for (int i = 0; i < NALM; i++) begin
            if (((int'(alarm_on) >> i) & 1) == 0 || tm) begin
                st[i] = S_IDLE;
            end else if (st[i] == S_IDLE) begin
                if (m_mev && f_min() == a_min[i] && f_hr() == a_hr[i] && day_ok(i)) begin
                    st[i] = S_RING; rleft[i] = RING_SEC;
                end
            end else if (st[i] == S_RING) begin
                if (stop) st[i] = S_IDLE;
                else if (snooze) begin st[i] = S_SNZ; sleft[i] = SNOOZE_MIN; end
                else if (pulse) begin
                    rleft[i]--;
                    if (rleft[i] == 0) st[i] = S_IDLE;
                end
            end else begin
                if (stop) st[i] = S_IDLE;
                else if (m_mev) begin
                    sleft[i]--;
                    if (sleft[i] == 0) begin st[i] = S_RING; rleft[i] = RING_SEC; end
                end
            end
        end
        if (am && pulse && int'(alarm_sel) < NALM) begin
            sel = int'(alarm_sel);
            if (minadv) a_min[sel] = (a_min[sel] + 1) % NS;
            if (hrsadv) a_hr[sel] = (a_hr[sel] + 1) % NH;
        end
        nmev = rm && pulse && (f_sec() == NS - 1);
        if (tm) begin
            mi = f_min(); h = f_hr(); d = f_day(); s = 0;
            if (pulse) begin
                if (minadv) mi = (mi + 1) % NS;
                if (hrsadv) h = (h + 1) % NH;
                if (dayadv) d = (d + 1) % ND;
            end
            m_tw = ((d * NH + h) * NS + mi) * NS + s;
        end else if (pulse) begin
            m_tw = (m_tw + 1) % WEEK;
        end
        m_mev = nmev;
    endtask

    task automatic compare();
        int ev, sel, edm, edh;
        ev = 0;
        for (int i = 0; i < NALM; i++) if (st[i] == S_RING) ev += (1 << i);
        sel = int'(alarm_sel);
        if (sel >= NALM) sel = 0;
        edm = f_min(); edh = f_hr();
        if (!timeset && alarmset) begin edm = a_min[sel]; edh = a_hr[sel]; end
        chk("tsec", 32'(tsec), 32'(f_sec()));
        chk("tmin", 32'(tmin), 32'(f_min()));
        chk("thrs", 32'(thrs), 32'(f_hr()));
        chk("tday", 32'(tday), 32'(f_day()));
        chk("disp_min", 32'(disp_min), 32'(edm));
        chk("disp_hrs", 32'(disp_hrs), 32'(edh));
        chk("ring_vec", 32'(ring_vec), 32'(ev));
        chk("buzz", 32'(buzz), 32'(ev != 0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
        @(negedge clk);
    endtask

    task automatic pulses(input int n);
        pulse = 1'b1;
        repeat (n) tick();
        pulse = 1'b0;
    endtask

    task automatic one_pulse();
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
    endtask

    task automatic run_to(input int h, input int m, input int s);
        int n = 0;
        timeset = 1'b0;
        alarmset = 1'b0;
        while (!(f_hr() == h && f_min() == m && f_sec() == s) && n < 4000) begin
            pulse = 1'b1;
            tick();
            n++;
        end
        pulse = 1'b0;
        if (n >= 4000) begin
            n_chk++; n_err++;
            $display("FAIL run_to: target %0d:%0d:%0d not reached in 4000 pulses", h, m, s);
        end
    endtask

    // Steps time (is_alarm=0) or alarm[sel] (is_alarm=1) toward h:m using the current mode.
    task automatic adv_to(input bit is_alarm, input int sel, input int h, input int m);
        int n = 0;
        int cm, ch;
        while (n < 200) begin
            cm = is_alarm ? a_min[sel] : f_min();
            ch = is_alarm ? a_hr[sel] : f_hr();
            if (cm == m && ch == h) break;
            minadv = (cm != m);
            hrsadv = (ch != h);
            pulse = 1'b1;
            tick();
            n++;
        end
        pulse = 1'b0; minadv = 1'b0; hrsadv = 1'b0;
        if (n >= 200) begin
            n_chk++; n_err++;
            $display("FAIL adv_to: target %0d:%0d not reached", h, m);
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        tick();
        tick();
        chk("lit_reset_tsec", 32'(tsec), 32'd0);
        chk("lit_reset_thrs", 32'(thrs), 32'd0);
        chk("lit_reset_tday", 32'(tday), 32'd0);
        chk("lit_reset_buzz", 32'(buzz), 32'd0);
        rst = 1'b1;
        tick();

        pulses(3600);
        chk("lit_1h_tsec", 32'(tsec), 32'd0);
        chk("lit_1h_tmin", 32'(tmin), 32'd0);
        chk("lit_1h_thrs", 32'(thrs), 32'd1);
        chk("lit_1h_tday", 32'(tday), 32'd0);

        timeset = 1'b1;
        adv_to(1'b0, 0, 23, 59);
        run_to(23, 59, 59);
        one_pulse();
        chk("lit_daywrap_thrs", 32'(thrs), 32'd0);
        chk("lit_daywrap_tmin", 32'(tmin), 32'd0);
        chk("lit_daywrap_tday", 32'(tday), 32'd1);

        pulses(5);
        timeset = 1'b1;
        tick();
        chk("lit_tset_sec0", 32'(tsec), 32'd0);
        adv_to(1'b0, 0, 0, 59);
        minadv = 1'b1;
        one_pulse();
        minadv = 1'b0;
        chk("lit_tset_minwrap", 32'(tmin), 32'd0);
        chk("lit_tset_nocarry", 32'(thrs), 32'd0);
        chk("lit_tset_sec", 32'(tsec), 32'd0);
        dayadv = 1'b1; hrsadv = 1'b1;
        one_pulse();
        dayadv = 1'b0; hrsadv = 1'b0;
        chk("lit_tset_day", 32'(tday), 32'd2);
        chk("lit_tset_hr", 32'(thrs), 32'd1);

        adv_to(1'b0, 0, 6, 29);
        timeset = 1'b0;
        alarmset = 1'b1;
        alarm_sel = 1'b1;
        adv_to(1'b1, 1, 6, 30);
        chk("lit_aset_disp_hrs", 32'(disp_hrs), 32'd6);
        chk("lit_aset_disp_min", 32'(disp_min), 32'd30);
        alarmset = 1'b0;
        alarm_on = 2'b10;
        run_to(6, 29, 59);
        one_pulse();
        chk("lit_match_tmin", 32'(tmin), 32'd30);
        chk("lit_match_buzz_early", 32'(buzz), 32'd0);
        tick();
        chk("lit_ring_buzz", 32'(buzz), 32'd1);
        chk("lit_ring_vec", 32'(ring_vec), 32'd2);
        pulses(29);
        chk("lit_ring29_buzz", 32'(buzz), 32'd1);
        pulses(1);
        chk("lit_timeout_buzz", 32'(buzz), 32'd0);

        alarmset = 1'b1;
        adv_to(1'b1, 1, 6, 31);
        alarmset = 1'b0;
        run_to(6, 30, 59);
        one_pulse();
        tick();
        chk("lit_ring2_buzz", 32'(buzz), 32'd1);
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
        chk("lit_snooze_buzz", 32'(buzz), 32'd0);
        run_to(6, 35, 59);
        chk("lit_snoozed_buzz", 32'(buzz), 32'd0);
        one_pulse();
        tick();
        chk("lit_resnooze_buzz", 32'(buzz), 32'd1);
        chk("lit_resnooze_vec", 32'(ring_vec), 32'd2);
        stop = 1'b1; snooze = 1'b1;
        tick();
        stop = 1'b0; snooze = 1'b0;
        chk("lit_stop_buzz", 32'(buzz), 32'd0);
        run_to(6, 40, 59);
        one_pulse();
        tick();
        chk("lit_stopwins_buzz", 32'(buzz), 32'd0);

        alarmset = 1'b1;
        alarm_sel = 1'b1;
        adv_to(1'b1, 1, 7, 0);
        alarm_sel = 1'b0;
        adv_to(1'b1, 0, 7, 0);
        chk("lit_aset0_disp_hrs", 32'(disp_hrs), 32'd7);
        chk("lit_aset0_disp_min", 32'(disp_min), 32'd0);
        alarmset = 1'b0;
        alarm_on = 2'b11;
        timeset = 1'b1;
        adv_to(1'b0, 0, 6, 59);
        timeset = 1'b0;
        run_to(6, 59, 59);
        one_pulse();
        tick();
        chk("lit_dual_vec", 32'(ring_vec), 32'd3);
        chk("lit_dual_buzz", 32'(buzz), 32'd1);
        alarm_on = 2'b10;
        tick();
        chk("lit_off0_vec", 32'(ring_vec), 32'd2);
        chk("lit_off0_buzz", 32'(buzz), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("lit_arst_buzz", 32'(buzz), 32'd0);
        chk("lit_arst_vec", 32'(ring_vec), 32'd0);
        chk("lit_arst_tmin", 32'(tmin), 32'd0);
        chk("lit_arst_thrs", 32'(thrs), 32'd0);
        chk("lit_arst_tsec", 32'(tsec), 32'd0);
        model_reset();
        tick();
        rst = 1'b1;
        alarm_on = 2'b00;
        tick();
        tick();

`ifdef ALARM_DAYMASK_EN
        alarmset = 1'b1;
        alarm_sel = 1'b0;
        adv_to(1'b1, 0, 0, 1);
        alarmset = 1'b0;
        amask = '0;
        amask[2] = 1'b1;
        alarm_on = 2'b01;
        timeset = 1'b1; dayadv = 1'b1;
        one_pulse();
        dayadv = 1'b0; timeset = 1'b0;
        run_to(0, 0, 59);
        one_pulse();
        tick();
        chk("lit_mask_day1_buzz", 32'(buzz), 32'd0);
        timeset = 1'b1; dayadv = 1'b1;
        one_pulse();
        dayadv = 1'b0;
        adv_to(1'b0, 0, 0, 0);
        timeset = 1'b0;
        run_to(0, 0, 59);
        one_pulse();
        tick();
        chk("lit_mask_day2_buzz", 32'(buzz), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
